// File: rtl/spi_reg_writer.sv
// spi_reg_writer: mode-0 SPI master that serialises 16-bit {write, addr, data} register frames
module spi_reg_writer #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_write,
  input  logic [6:0] i_req_addr,
  input  logic [7:0] i_req_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ncs,
  output logic       o_sclk,
  output logic       o_copi
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [4:0]    r_edge, w_edge;
  logic [GW-1:0] r_gap, w_gap;
  logic [15:0]   r_sr, w_sr;
  logic          r_ncs, w_ncs;
  logic          r_sclk, w_sclk;
  logic          r_copi, w_copi;
  logic          r_done, w_done;
  logic          w_half_end;
  assign w_half_end  = r_cnt == C_LAST;
  assign o_req_ready = r_state == IDLE;
  assign o_busy      = r_state != IDLE;
  assign o_done      = r_done;
  assign o_ncs       = r_ncs;
  assign o_sclk      = r_sclk;
  assign o_copi      = r_copi;
  // State, counters, shift register and registered pin drivers; reset idles the bus immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_edge  <= '0;
      r_gap   <= '0;
      r_sr    <= '0;
      r_ncs   <= 1'b1;
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_edge  <= w_edge;
      r_gap   <= w_gap;
      r_sr    <= w_sr;
      r_ncs   <= w_ncs;
      r_sclk  <= w_sclk;
      r_copi  <= w_copi;
      r_done  <= w_done;
    end
  end
  // Next state and next pin values; COPI only moves on SCLK falls so each bit has D cycles of setup and hold
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_edge  = r_edge;
    w_gap   = r_gap;
    w_sr    = r_sr;
    w_ncs   = r_ncs;
    w_sclk  = r_sclk;
    w_copi  = r_copi;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_state = SETUP;
          w_sr    = {i_req_write, i_req_addr, i_req_data};
          w_cnt   = '0;
          w_ncs   = 1'b0;
          w_sclk  = 1'b0;
          w_copi  = i_req_write;
        end
      end
      SETUP: begin
        w_cnt = w_half_end ? '0 : r_cnt + 1'b1;
        if (w_half_end) begin
          w_state = SHIFT;
          w_edge  = '0;
          w_sclk  = 1'b1;
        end
      end
      SHIFT: begin
        w_cnt = w_half_end ? '0 : r_cnt + 1'b1;
        if (w_half_end && r_edge == 5'd31) begin
          w_state = GAP;
          w_gap   = '0;
          w_ncs   = 1'b1;
          w_sclk  = 1'b0;
          w_copi  = 1'b0;
        end else if (w_half_end) begin
          w_edge = r_edge + 5'd1;
          w_sclk = ~r_sclk;
          if (r_sclk) begin
            w_sr   = {r_sr[14:0], 1'b0};
            w_copi = (r_edge == 5'd30) ? 1'b0 : r_sr[14];
          end
        end
      end
      GAP: begin
        w_gap = (r_gap == G_LAST) ? '0 : r_gap + 1'b1;
        if (r_gap == G_LAST) begin
          w_state = IDLE;
          w_done  = 1'b1;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_spi_reg_writer.sv
// tb_spi_reg_writer: random-stimulus bench with a timing-formula waveform model and an SPI register-file receiver
module tb_spi_reg_writer;
  localparam int D = 4;
  localparam int G = 4;
  localparam int T = 33 * D + G + 1;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_req_valid = 1'b0;
  logic       i_req_write = 1'b0;
  logic [6:0] i_req_addr = '0;
  logic [7:0] i_req_data = '0;
  logic       o_req_ready, o_busy, o_done, o_ncs, o_sclk, o_copi;
  int         errors = 0;
  int         checks = 0;
  int         w_err, w_t;
  logic [5:0] w_act, w_exp;
  bit [7:0]   rx_regs [128];
  bit [7:0]   exp_regs [128];
  bit [15:0]  rx_sr, rx_word;
  int         rx_n, rx_bits;
  bit         p_ncs, p_sclk;

  spi_reg_writer #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_busy(o_busy), .o_done(o_done), .o_ncs(o_ncs), .o_sclk(o_sclk), .o_copi(o_copi)
  );

  always #5 clk = ~clk;

  // Receiving register file: shifts COPI on SCLK rise while selected, commits only complete write frames
  always @(o_ncs, o_sclk) begin
    if (p_ncs && !o_ncs) rx_n = 0;
    if (!p_sclk && o_sclk && !o_ncs) begin
      rx_sr = {rx_sr[14:0], o_copi};
      rx_n++;
    end
    if (!p_ncs && o_ncs) begin
      rx_word = rx_sr;
      rx_bits = rx_n;
      if (rx_n == 16 && rx_sr[15]) rx_regs[rx_sr[14:8]] = rx_sr[7:0];
    end
    p_ncs  = o_ncs;
    p_sclk = o_sclk;
  end

  // Expected {ready, busy, done, ncs, sclk, copi} at cycle t after the handshake, from the frame timing formulas
  function automatic logic [5:0] exp_vec(int t, logic [15:0] f);
    int   nf = 0;
    logic sck = 1'b0;
    logic cp;
    for (int k = 1; k <= 16; k++) begin
      if (t >= 1 + 2 * k * D) nf++;
      if (t >= 1 + (2 * k - 1) * D && t < 1 + 2 * k * D) sck = 1'b1;
    end
    cp = (t >= 1 && t <= 33 * D && nf < 16) ? f[15-nf] : 1'b0;
    return {t == T, t >= 1 && t < T, t == T, !(t >= 1 && t <= 33 * D), sck, cp};
  endfunction

  function automatic int reg_diff();
    int n = 0;
    for (int i = 0; i < 128; i++) if (rx_regs[i] !== exp_regs[i]) n++;
    return n;
  endfunction

  // Entered at the negedge of the handshake cycle with the request driven; returns at the done-cycle negedge
  task automatic run_frame(input logic [15:0] f, input bit scr, input bit chain, input logic [15:0] nf);
    logic [5:0] a, e;
    w_err = 0;
    if (f[15]) exp_regs[f[14:8]] = f[7:0];
    @(negedge clk);
    for (int t = 1; t <= T; t++) begin
      a = {o_req_ready, o_busy, o_done, o_ncs, o_sclk, o_copi};
      e = exp_vec(t, f);
      if (a !== e) begin
        if (w_err == 0) begin
          w_t   = t;
          w_act = a;
          w_exp = e;
        end
        w_err++;
      end
      if (t < T) begin
        if (t == T - 1) begin
          i_req_valid = chain;
          if (chain) {i_req_write, i_req_addr, i_req_data} = nf;
        end else if (scr) begin
          i_req_valid = 1'b1;
          {i_req_write, i_req_addr, i_req_data} = 16'($urandom);
        end else i_req_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic drive(input logic [15:0] f);
    i_req_valid = 1'b1;
    {i_req_write, i_req_addr, i_req_data} = f;
  endtask

  task automatic test_reset();
    logic [5:0] a;
    repeat (3) @(negedge clk);
    a = {o_req_ready, o_busy, o_done, o_ncs, o_sclk, o_copi};
    checks++;
    if (a !== 6'b100100) begin
      errors++;
      $display("FAIL reset_state got=%b want=100100 (ready busy done ncs sclk copi)", a);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    a = {o_req_ready, o_busy, o_done, o_ncs, o_sclk, o_copi};
    checks++;
    if (a !== 6'b100100) begin
      errors++;
      $display("FAIL idle_after_release got=%b want=100100", a);
    end
  endtask

  task automatic test_single();
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got=%b want=1", o_req_ready);
    end
    drive(16'h85A5);
    run_frame(16'h85A5, 0, 0, 16'h0);
    checks++;
    if (w_err !== 0) begin
      errors++;
      $display("FAIL single_wave t=%0d got=%b want=%b bad_cycles=%0d", w_t, w_act, w_exp, w_err);
    end
    checks++;
    if (rx_word !== 16'h85A5 || rx_bits !== 16) begin
      errors++;
      $display("FAIL single_rx word=%h bits=%0d want=85a5/16", rx_word, rx_bits);
    end
    checks++;
    if (rx_regs[5] !== 8'hA5) begin
      errors++;
      $display("FAIL single_reg5 got=%h want=a5", rx_regs[5]);
    end
  endtask

  task automatic test_loopback();
    logic [6:0] ad [5] = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h05};
    logic [7:0] dt [5] = '{8'hFF, 8'h0F, 8'hAA, 8'h55, 8'h80};
    for (int i = 0; i < 5; i++) begin
      repeat (2) @(negedge clk);
      drive({1'b1, ad[i], dt[i]});
      run_frame({1'b1, ad[i], dt[i]}, 0, 0, 16'h0);
      checks++;
      if (w_err !== 0) begin
        errors++;
        $display("FAIL loop%0d_wave t=%0d got=%b want=%b", i, w_t, w_act, w_exp);
      end
      checks++;
      if (reg_diff() !== 0 || rx_regs[ad[i]] !== dt[i]) begin
        errors++;
        $display("FAIL loop%0d_regs diffs=%0d reg=%h want=%h", i, reg_diff(), rx_regs[ad[i]], dt[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    repeat (2) @(negedge clk);
    drive(16'h813C);
    run_frame(16'h813C, 0, 1, 16'h82C3);
    checks++;
    if (w_err !== 0 || rx_word !== 16'h813C) begin
      errors++;
      $display("FAIL b2b_first t=%0d got=%b want=%b word=%h", w_t, w_act, w_exp, rx_word);
    end
    run_frame(16'h82C3, 0, 0, 16'h0);
    checks++;
    if (w_err !== 0 || rx_word !== 16'h82C3) begin
      errors++;
      $display("FAIL b2b_second t=%0d got=%b want=%b word=%h", w_t, w_act, w_exp, rx_word);
    end
    checks++;
    if (rx_regs[1] !== 8'h3C || rx_regs[2] !== 8'hC3 || reg_diff() !== 0) begin
      errors++;
      $display("FAIL b2b_regs r1=%h r2=%h want=3c/c3 diffs=%0d", rx_regs[1], rx_regs[2], reg_diff());
    end
  endtask

  task automatic test_stability();
    logic [15:0] f;
    repeat (2) @(negedge clk);
    f = {1'b1, 15'($urandom)};
    drive(f);
    run_frame(f, 1, 0, 16'h0);
    checks++;
    if (w_err !== 0 || rx_word !== f) begin
      errors++;
      $display("FAIL stable_wave t=%0d got=%b want=%b word=%h frame=%h", w_t, w_act, w_exp, rx_word, f);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_ncs !== 1'b1 || reg_diff() !== 0) begin
      errors++;
      $display("FAIL stable_no_second busy=%b ncs=%b diffs=%0d want=0/1/0", o_busy, o_ncs, reg_diff());
    end
  endtask

  task automatic test_write0();
    repeat (2) @(negedge clk);
    drive(16'h0512);
    run_frame(16'h0512, 0, 0, 16'h0);
    checks++;
    if (w_err !== 0 || rx_bits !== 16 || rx_word !== 16'h0512) begin
      errors++;
      $display("FAIL write0_wave t=%0d got=%b want=%b bits=%0d", w_t, w_act, w_exp, rx_bits);
    end
    checks++;
    if (reg_diff() !== 0 || rx_regs[5] !== 8'h80) begin
      errors++;
      $display("FAIL write0_regs reg5=%h want=80 diffs=%0d", rx_regs[5], reg_diff());
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] a;
    repeat (2) @(negedge clk);
    drive(16'h8633);
    @(negedge clk);
    i_req_valid = 1'b0;
    repeat (1 + 13 * D) @(negedge clk);
    checks++;
    if (o_sclk !== 1'b1 || o_ncs !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_reset sclk=%b ncs=%b want=1/0", o_sclk, o_ncs);
    end
    #2 rst_n = 1'b0;
    #1 a = {o_req_ready, o_busy, o_done, o_ncs, o_sclk, o_copi};
    checks++;
    if (a !== 6'b100100) begin
      errors++;
      $display("FAIL mid_async_reset got=%b want=100100", a);
    end
    checks++;
    if (rx_bits !== 7 || reg_diff() !== 0) begin
      errors++;
      $display("FAIL mid_truncated bits=%0d want=7 diffs=%0d", rx_bits, reg_diff());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(16'h8633);
    run_frame(16'h8633, 0, 0, 16'h0);
    checks++;
    if (w_err !== 0 || rx_word !== 16'h8633 || reg_diff() !== 0) begin
      errors++;
      $display("FAIL mid_recover t=%0d got=%b want=%b word=%h", w_t, w_act, w_exp, rx_word);
    end
  endtask

  task automatic test_random();
    logic [15:0] f;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(3)) @(negedge clk);
      f = 16'($urandom);
      drive(f);
      run_frame(f, 0, 0, 16'h0);
      checks++;
      if (w_err !== 0 || rx_word !== f || reg_diff() !== 0) begin
        errors++;
        $display("FAIL rand%0d frame=%h t=%0d got=%b want=%b word=%h diffs=%0d", i, f, w_t, w_act, w_exp, rx_word, reg_diff());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_loopback();
    test_back_to_back();
    test_stability();
    test_write0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
